// File: rtl/tpu_pkg.sv
// Shared definitions for the convolution scheduler.
//   state_t      : scheduler FSM states
//   calc_*       : derivation of address / kernel_dim / length widths
//   win_addr     : window start address of output position (r,c)
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SETUP,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } state_t;

  function automatic int unsigned calc_addr_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h);
  endfunction

  function automatic int unsigned calc_kd_w(input int unsigned w);
    return $clog2(w);
  endfunction

  function automatic int unsigned calc_len_w(input int unsigned w);
    int unsigned k;
    k = $clog2(w) - 1;
    return k * k + 1;
  endfunction

  // Caller truncates to the address width, so overflow simply wraps.
  function automatic int unsigned win_addr(input int unsigned base, input int unsigned r,
                                           input int unsigned c, input int unsigned img_w);
    return base + r * img_w + c;
  endfunction

endpackage

// File: rtl/tpu_result_drain.sv
// Captures one batch of TPU results and serializes the active units onto a
// valid/ready stream in ascending unit order.
//   capture   : load data/index/mask (one cycle)
//   mask      : units whose results are to be emitted
//   data_in   : per-unit result words
//   index_in  : per-unit output indices
//   res_*     : result stream, held stable while res_ready is low
//   last      : handshake of the final pending unit in this cycle
module tpu_result_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned NUM_UNITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture,
  input  logic [NUM_UNITS-1:0]            mask,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_UNITS*ADDR_W-1:0]     index_in,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic [ADDR_W-1:0]               res_index,
  output logic                            last
);

  logic [NUM_UNITS-1:0]            pending;
  logic [NUM_UNITS-1:0]            sel;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_q;
  logic [NUM_UNITS*ADDR_W-1:0]     index_q;

  // Lowest pending unit, one-hot.
  assign sel       = pending & (~pending + NUM_UNITS'(1));
  assign res_valid = |pending;
  assign last      = res_valid && res_ready && ((pending & ~sel) == '0);

  always_comb begin
    res_data  = '0;
    res_index = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (sel[i]) begin
        res_data  = data_q[i*DATA_WIDTH +: DATA_WIDTH];
        res_index = index_q[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else if (capture) begin
      pending <= mask;
      data_q  <= data_in;
      index_q <= index_in;
    end else if (res_valid && res_ready) begin
      pending <= pending & ~sel;
    end
  end

endmodule

// File: rtl/tpu_conv_scheduler.sv
// Sequences one valid-mode convolution job on the TPU: walks all output
// positions in row-major order, issues them in batches of NUM_UNITS, waits
// for each batch and streams the results out one pixel per handshake.
//   cmd_*      : job request (kernel_dim and base addresses), accepted in IDLE
//   tpu_*      : batch launch interface (addresses/mask held from SETUP through WAIT)
//   res_*      : result stream, res_index = r*OUT_W + c
//   busy       : high outside IDLE
//   job_done   : one-cycle pulse at job end; job_err accompanies it on a rejected job
module tpu_conv_scheduler
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 8,
  parameter int unsigned IMAGE_HEIGHT = 8,
  parameter int unsigned NUM_UNITS    = 2,
  parameter int unsigned ADDR_W       = calc_addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
  parameter int unsigned KD_W         = calc_kd_w(IMAGE_WIDTH),
  parameter int unsigned LEN_W        = calc_len_w(IMAGE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [KD_W-1:0]                 cmd_kernel_dim,
  input  logic [ADDR_W-1:0]               cmd_img_base,
  input  logic [ADDR_W-1:0]               cmd_kernel_base,
  input  logic [ADDR_W-1:0]               cmd_bias_base,
  output logic                            tpu_start,
  output logic [NUM_UNITS-1:0]            tpu_active_units,
  output logic [NUM_UNITS*ADDR_W-1:0]     tpu_start_addr_1,
  output logic [NUM_UNITS*ADDR_W-1:0]     tpu_start_addr_2,
  output logic [NUM_UNITS*ADDR_W-1:0]     tpu_bias_addr,
  output logic [KD_W-1:0]                 tpu_kernel_dim,
  output logic [LEN_W-1:0]                tpu_length,
  input  logic                            tpu_done,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] tpu_relu_out,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic [ADDR_W-1:0]               res_index,
  output logic                            busy,
  output logic                            job_done,
  output logic                            job_err
);

  // Cursor width must reach IMAGE_WIDTH/IMAGE_HEIGHT themselves.
  localparam int unsigned CW      = ADDR_W + 1;
  localparam int unsigned LEN_MAX = (32'd1 << LEN_W) - 32'd1;

  state_t state, state_next;

  logic [KD_W-1:0]             kd;
  logic [ADDR_W-1:0]           img_base, kernel_base, bias_base;
  logic                        err;
  logic [CW-1:0]               cur_r, cur_c;
  logic [CW-1:0]               out_w, out_h;
  logic [2*KD_W-1:0]           kd_sq;
  logic                        kd_bad;
  logic [NUM_UNITS-1:0]        plan_mask;
  logic [NUM_UNITS*ADDR_W-1:0] plan_addr, plan_idx, unit_idx;
  logic [CW-1:0]               walk_r, walk_c;
  logic                        capture, drain_last;

  assign out_w  = CW'(IMAGE_WIDTH) - CW'(kd) + CW'(1);
  assign out_h  = CW'(IMAGE_HEIGHT) - CW'(kd) + CW'(1);
  assign kd_sq  = {{KD_W{1'b0}}, kd} * {{KD_W{1'b0}}, kd};
  assign kd_bad = (kd == '0) || (32'(kd) > IMAGE_HEIGHT) || (32'(kd_sq) > LEN_MAX);

  assign tpu_start_addr_2 = {NUM_UNITS{kernel_base}};
  assign tpu_bias_addr    = {NUM_UNITS{bias_base}};
  assign tpu_kernel_dim   = kd;
  assign tpu_length       = LEN_W'(kd_sq);

  // Walk NUM_UNITS positions forward from the cursor; walk_r/walk_c end up
  // as the next cursor (walk_r >= out_h means the job has no positions left).
  always_comb begin
    plan_mask = '0;
    plan_addr = '0;
    plan_idx  = '0;
    walk_r    = cur_r;
    walk_c    = cur_c;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      plan_mask[i] = (walk_r < out_h);
      plan_addr[i*ADDR_W +: ADDR_W] =
        ADDR_W'(win_addr(32'(img_base), 32'(walk_r), 32'(walk_c), IMAGE_WIDTH));
      plan_idx[i*ADDR_W +: ADDR_W] = ADDR_W'(32'(walk_r) * 32'(out_w) + 32'(walk_c));
      if (walk_c == out_w - CW'(1)) begin
        walk_c = '0;
        walk_r = walk_r + CW'(1);
      end else begin
        walk_c = walk_c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    tpu_start  = 1'b0;
    job_done   = 1'b0;
    job_err    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = S_CHECK;
      end
      S_CHECK:  state_next = kd_bad ? S_FINISH : S_SETUP;
      S_SETUP:  state_next = S_LAUNCH;
      S_LAUNCH: begin
        tpu_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tpu_done) begin
          capture    = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_last) state_next = (cur_r < out_h) ? S_SETUP : S_FINISH;
      end
      S_FINISH: begin
        job_done   = 1'b1;
        job_err    = err;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kd               <= '0;
      img_base         <= '0;
      kernel_base      <= '0;
      bias_base        <= '0;
      err              <= 1'b0;
      cur_r            <= '0;
      cur_c            <= '0;
      tpu_active_units <= '0;
      tpu_start_addr_1 <= '0;
      unit_idx         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            kd          <= cmd_kernel_dim;
            img_base    <= cmd_img_base;
            kernel_base <= cmd_kernel_base;
            bias_base   <= cmd_bias_base;
            err         <= 1'b0;
          end
        end
        S_CHECK: begin
          err   <= kd_bad;
          cur_r <= '0;
          cur_c <= '0;
        end
        S_SETUP: begin
          tpu_active_units <= plan_mask;
          tpu_start_addr_1 <= plan_addr;
          unit_idx         <= plan_idx;
          cur_r            <= walk_r;
          cur_c            <= walk_c;
        end
        default: ;
      endcase
    end
  end

  tpu_result_drain #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (ADDR_W),
    .NUM_UNITS (NUM_UNITS)
  ) u_drain (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .mask     (tpu_active_units),
    .data_in  (tpu_relu_out),
    .index_in (unit_idx),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_index(res_index),
    .last     (drain_last)
  );

endmodule

// File: tb/tb_tpu_conv_scheduler.sv
// Directed bench for tpu_conv_scheduler: 8x8 image, NUM_UNITS=2 main instance
// plus a NUM_UNITS=3 instance. A behavioural TPU answers each launch after
// LAT cycles with result = base_code + window address.
module tb_tpu_conv_scheduler;

  localparam int unsigned DW = 16, IW = 8, IH = 8, NU = 2, AW = 6, KW = 3, LW = 5, LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           cmd_valid, cmd_ready;
  logic [KW-1:0]  cmd_kernel_dim;
  logic [AW-1:0]  cmd_img_base, cmd_kernel_base, cmd_bias_base;
  logic           tpu_start;
  logic [NU-1:0]  tpu_active_units;
  logic [NU*AW-1:0] tpu_start_addr_1, tpu_start_addr_2, tpu_bias_addr;
  logic [KW-1:0]  tpu_kernel_dim;
  logic [LW-1:0]  tpu_length;
  logic           tpu_done;
  logic [NU*DW-1:0] tpu_relu_out;
  logic           res_valid, res_ready;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  res_index;
  logic           busy, job_done, job_err;

  tpu_conv_scheduler #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kernel_dim(cmd_kernel_dim),
    .cmd_img_base(cmd_img_base), .cmd_kernel_base(cmd_kernel_base), .cmd_bias_base(cmd_bias_base),
    .tpu_start(tpu_start), .tpu_active_units(tpu_active_units),
    .tpu_start_addr_1(tpu_start_addr_1), .tpu_start_addr_2(tpu_start_addr_2),
    .tpu_bias_addr(tpu_bias_addr), .tpu_kernel_dim(tpu_kernel_dim), .tpu_length(tpu_length),
    .tpu_done(tpu_done), .tpu_relu_out(tpu_relu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index),
    .busy(busy), .job_done(job_done), .job_err(job_err)
  );

  // Three-unit instance
  logic           cmd_valid3, cmd_ready3;
  logic [KW-1:0]  cmd_kernel_dim3;
  logic           tpu_start3, tpu_done3;
  logic [2:0]     tpu_active_units3;
  logic [3*AW-1:0] tpu_start_addr_13, tpu_start_addr_23, tpu_bias_addr3;
  logic [KW-1:0]  tpu_kernel_dim3;
  logic [LW-1:0]  tpu_length3;
  logic [3*DW-1:0] tpu_relu_out3;
  logic           res_valid3, res_ready3;
  logic [DW-1:0]  res_data3;
  logic [AW-1:0]  res_index3;
  logic           busy3, job_done3, job_err3;

  tpu_conv_scheduler #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(3)
  ) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_kernel_dim(cmd_kernel_dim3),
    .cmd_img_base('0), .cmd_kernel_base('0), .cmd_bias_base('0),
    .tpu_start(tpu_start3), .tpu_active_units(tpu_active_units3),
    .tpu_start_addr_1(tpu_start_addr_13), .tpu_start_addr_2(tpu_start_addr_23),
    .tpu_bias_addr(tpu_bias_addr3), .tpu_kernel_dim(tpu_kernel_dim3), .tpu_length(tpu_length3),
    .tpu_done(tpu_done3), .tpu_relu_out(tpu_relu_out3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3), .res_index(res_index3),
    .busy(busy3), .job_done(job_done3), .job_err(job_err3)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- main-instance monitor (samples on negedge) ----------------
  int starts, done_cnt, err_cnt, busy_cyc, hold_viol, stall_cyc;
  logic [NU-1:0]    mask_log[$];
  logic [NU*AW-1:0] addr_log[$];
  logic [DW-1:0]    data_log[$];
  logic [AW-1:0]    idx_log[$];
  logic             prev_stall;
  logic [DW-1:0]    prev_data;
  logic [AW-1:0]    prev_idx;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (busy === 1'b1) busy_cyc++;
      if (job_done === 1'b1) done_cnt++;
      if (job_err === 1'b1) err_cnt++;
      if (tpu_start === 1'b1) begin
        starts++;
        mask_log.push_back(tpu_active_units);
        addr_log.push_back(tpu_start_addr_1);
      end
      if (prev_stall && (res_valid !== 1'b1 || res_data !== prev_data || res_index !== prev_idx))
        hold_viol++;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        data_log.push_back(res_data);
        idx_log.push_back(res_index);
      end
      if (res_valid === 1'b1 && res_ready === 1'b0) stall_cyc++;
      prev_stall = (res_valid === 1'b1) && (res_ready === 1'b0);
      prev_data  = res_data;
      prev_idx   = res_index;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- behavioural TPU, main instance ----------------
  logic [NU*AW-1:0] resp_addr;
  initial begin
    tpu_done = 1'b0;
    tpu_relu_out = '0;
    forever begin
      @(negedge clk);
      if (tpu_start === 1'b1) begin
        resp_addr = tpu_start_addr_1;
        repeat (LAT) @(posedge clk);
        #1;
        for (int i = 0; i < NU; i++)
          tpu_relu_out[i*DW +: DW] = 16'h1000 + 16'(resp_addr[i*AW +: AW]);
        tpu_done = 1'b1;
        @(posedge clk);
        #1 tpu_done = 1'b0;
      end
    end
  end

  // ---------------- res_ready driver: 0 = always ready, 1 = pattern 1,0,0,1 ----------------
  int ready_mode = 0;
  int rcyc = 0;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        res_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
        rcyc++;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // ---------------- three-unit instance: TPU model and monitor ----------------
  int starts3, done3, res_cnt3, order_bad3;
  logic [2:0] last_mask3;
  logic [3*AW-1:0] resp_addr3;
  assign res_ready3 = 1'b1;

  initial begin
    tpu_done3 = 1'b0;
    tpu_relu_out3 = '0;
    forever begin
      @(negedge clk);
      if (tpu_start3 === 1'b1) begin
        resp_addr3 = tpu_start_addr_13;
        repeat (LAT) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
          tpu_relu_out3[i*DW +: DW] = 16'h2000 + 16'(resp_addr3[i*AW +: AW]);
        tpu_done3 = 1'b1;
        @(posedge clk);
        #1 tpu_done3 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (tpu_start3 === 1'b1) begin
        starts3++;
        last_mask3 = tpu_active_units3;
      end
      if (job_done3 === 1'b1) done3++;
      if (res_valid3 === 1'b1) begin
        if (res_index3 !== AW'(res_cnt3) || res_data3 !== 16'h2000 + 16'(res_cnt3 % 64))
          order_bad3++;
        res_cnt3++;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] exp_pix(input int base, input int k, input int ow);
    return 16'h1000 + 16'((base + (k / ow) * IW + (k % ow)) % 64);
  endfunction

  task automatic clear_logs();
    starts = 0; done_cnt = 0; err_cnt = 0; busy_cyc = 0; hold_viol = 0; stall_cyc = 0;
    mask_log.delete(); addr_log.delete(); data_log.delete(); idx_log.delete();
  endtask

  task automatic run_job(input logic [KW-1:0] k, input logic [AW-1:0] ib,
                         input logic [AW-1:0] kb, input logic [AW-1:0] bb);
    bit timed_out;
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_kernel_dim = k;
    cmd_img_base = ib; cmd_kernel_base = kb; cmd_bias_base = bb;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk); #2;
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL job_timeout kd=%0d: job_done not seen within 2000 cycles", k);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_results(input string name, input int n_exp, input int base, input int ow);
    int bad;
    checks++;
    if (data_log.size() !== n_exp) begin
      errors++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, data_log.size(), n_exp);
    end
    bad = 0;
    for (int k = 0; k < data_log.size(); k++)
      if (idx_log[k] !== AW'(k) || data_log[k] !== exp_pix(base, k, ow)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_order: %0d results with wrong index/data, expected 0", name, bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [72:0] snap;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    snap = {tpu_start, busy, tpu_active_units, tpu_start_addr_1, tpu_start_addr_2, tpu_bias_addr,
            tpu_kernel_dim, tpu_length, res_valid, res_data, res_index, job_done, job_err};
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", snap);
    end
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b/%b expected 1/1", cmd_ready, cmd_ready3);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_kd3();
    logic [NU*AW-1:0] a0, a3;
    int badmask;
    run_job(3'd3, 6'd0, 6'd0, 6'd0);
    checks++;
    if (starts !== 18) begin errors++; $display("FAIL kd3_starts: got %0d expected 18", starts); end
    badmask = 0;
    foreach (mask_log[i]) if (mask_log[i] !== 2'b11) badmask++;
    checks++;
    if (badmask !== 0) begin errors++; $display("FAIL kd3_masks: %0d masks not 11, expected 0", badmask); end
    a0 = (addr_log.size() > 0) ? addr_log[0] : '1;
    a3 = (addr_log.size() > 3) ? addr_log[3] : '1;
    checks++;
    if (a0 !== {6'd1, 6'd0}) begin errors++; $display("FAIL kd3_batch0_addr: got %h expected %h", a0, {6'd1, 6'd0}); end
    checks++;
    if (a3 !== {6'd9, 6'd8}) begin errors++; $display("FAIL kd3_batch3_addr: got %h expected %h", a3, {6'd9, 6'd8}); end
    check_results("kd3", 36, 0, 6);
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      errors++; $display("FAIL kd3_done: got done=%0d err=%0d expected 1/0", done_cnt, err_cnt);
    end
    checks++;
    if (busy_cyc !== 110) begin errors++; $display("FAIL kd3_latency: got %0d busy cycles expected 110", busy_cyc); end
    checks++;
    if (tpu_length !== 5'd9 || tpu_kernel_dim !== 3'd3) begin
      errors++; $display("FAIL kd3_len: got len=%0d kd=%0d expected 9/3", tpu_length, tpu_kernel_dim);
    end
  endtask

  task automatic test_kd5();
    logic [NU*AW-1:0] a4;
    run_job(3'd5, 6'd0, 6'd0, 6'd0);
    checks++;
    if (starts !== 8) begin errors++; $display("FAIL kd5_starts: got %0d expected 8", starts); end
    checks++;
    if (tpu_length !== 5'd25) begin errors++; $display("FAIL kd5_length: got %0d expected 25", tpu_length); end
    a4 = (addr_log.size() > 4) ? addr_log[4] : '1;
    checks++;
    if (a4[AW-1:0] !== 6'd16) begin errors++; $display("FAIL kd5_row2_addr: got %0d expected 16", a4[AW-1:0]); end
    check_results("kd5", 16, 0, 4);
    checks++;
    if (busy_cyc !== 50) begin errors++; $display("FAIL kd5_latency: got %0d busy cycles expected 50", busy_cyc); end
  endtask

  task automatic test_reject();
    // kd=8 does not fit the 3-bit kernel_dim field and arrives as 0.
    logic [KW-1:0] rej [3] = '{3'd0, 3'd6, 3'd7};
    foreach (rej[j]) begin
      run_job(rej[j], 6'd0, 6'd0, 6'd0);
      checks++;
      if (starts !== 0 || done_cnt !== 1 || err_cnt !== 1 || busy_cyc !== 2) begin
        errors++;
        $display("FAIL reject_kd%0d: got starts=%0d done=%0d err=%0d busy=%0d expected 0/1/1/2",
                 rej[j], starts, done_cnt, err_cnt, busy_cyc);
      end
    end
  endtask

  task automatic test_partial();
    logic [NU-1:0] lm;
    int badmask;
    run_job(3'd2, 6'd40, 6'd5, 6'd9);
    checks++;
    if (starts !== 25) begin errors++; $display("FAIL part_starts: got %0d expected 25", starts); end
    lm = (mask_log.size() > 0) ? mask_log[mask_log.size()-1] : 'x;
    checks++;
    if (lm !== 2'b01) begin errors++; $display("FAIL part_last_mask: got %b expected 01", lm); end
    badmask = 0;
    for (int i = 0; i + 1 < mask_log.size(); i++) if (mask_log[i] !== 2'b11) badmask++;
    checks++;
    if (badmask !== 0) begin errors++; $display("FAIL part_full_masks: %0d not 11, expected 0", badmask); end
    check_results("part", 49, 40, 7);
    checks++;
    if (tpu_start_addr_2 !== {6'd5, 6'd5} || tpu_bias_addr !== {6'd9, 6'd9}) begin
      errors++; $display("FAIL part_kb_bias: got %h/%h expected 145/249", tpu_start_addr_2, tpu_bias_addr);
    end
    checks++;
    if (busy_cyc !== 151) begin errors++; $display("FAIL part_latency: got %0d busy cycles expected 151", busy_cyc); end
  endtask

  task automatic test_back_to_back_stall();
    ready_mode = 1;
    rcyc = 0;
    run_job(3'd5, 6'd3, 6'd0, 6'd0);
    ready_mode = 0;
    check_results("stall", 16, 3, 4);
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable stall cycles, expected 0", hold_viol); end
    checks++;
    if (stall_cyc < 1) begin errors++; $display("FAIL stall_seen: got %0d stall cycles expected >0", stall_cyc); end
  endtask

  task automatic test_reset_mid_job();
    logic [72:0] snap;
    bit seen;
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_kernel_dim = 3'd3; cmd_img_base = '0; cmd_kernel_base = '0; cmd_bias_base = '0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #2;
      if (starts > 0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_launch: no tpu_start within 100 cycles"); end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    snap = {tpu_start, busy, tpu_active_units, tpu_start_addr_1, tpu_start_addr_2, tpu_bias_addr,
            tpu_kernel_dim, tpu_length, res_valid, res_data, res_index, job_done, job_err};
    checks++;
    if (snap !== '0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_outputs: got %h ready=%b expected 0 ready=1", snap, cmd_ready);
    end
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d job_done expected 0", done_cnt); end
    run_job(3'd3, 6'd0, 6'd0, 6'd0);
    checks++;
    if (starts !== 18 || (addr_log.size() > 0 ? addr_log[0] : 12'hfff) !== {6'd1, 6'd0}) begin
      errors++; $display("FAIL rst_mid_rerun: got starts=%0d expected 18 with batch0 {1,0}", starts);
    end
    check_results("rerun", 36, 0, 6);
  endtask

  task automatic test_three_units();
    bit timed_out;
    starts3 = 0; done3 = 0; res_cnt3 = 0; order_bad3 = 0; last_mask3 = '0;
    @(posedge clk); #1;
    cmd_valid3 = 1'b1; cmd_kernel_dim3 = 3'd1;
    @(posedge clk); #1 cmd_valid3 = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #2;
      if (done3 > 0) begin timed_out = 1'b0; break; end
    end
    checks++;
    if (timed_out) begin errors++; $display("FAIL u3_timeout: job_done not seen within 3000 cycles"); end
    checks++;
    if (starts3 !== 22) begin errors++; $display("FAIL u3_starts: got %0d expected 22", starts3); end
    checks++;
    if (last_mask3 !== 3'b001) begin errors++; $display("FAIL u3_last_mask: got %b expected 001", last_mask3); end
    checks++;
    if (res_cnt3 !== 64 || order_bad3 !== 0) begin
      errors++; $display("FAIL u3_results: got %0d results, %0d bad, expected 64/0", res_cnt3, order_bad3);
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_kernel_dim = '0; cmd_img_base = '0; cmd_kernel_base = '0; cmd_bias_base = '0;
    cmd_valid3 = 1'b0; cmd_kernel_dim3 = '0;
    clear_logs();
    starts3 = 0; done3 = 0; res_cnt3 = 0; order_bad3 = 0; last_mask3 = '0;
    test_reset();
    test_kd3();
    test_kd5();
    test_reject();
    test_partial();
    test_back_to_back_stall();
    test_reset_mid_job();
    test_three_units();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
